// File: rtl/ahbl_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahbl_master_arbiter_if
// Bundles the requester command/response handshake and the AHB-Lite master
// signal set used by ahbl_master_arbiter.
//   master modport : the arbiter's view (drives REQ_READY, RSP_*, H* outputs)
//   slave  modport : the environment's view (requesters plus AHB-Lite slave)
// Requester i occupies REQ_ADDR/REQ_WDATA bits [32i+31:32i] and REQ_SIZE
// bits [3i+2:3i]. NUM_REQ must match the arbiter's NUM_REQ.
// ---------------------------------------------------------------------------
interface ahbl_master_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    REQ_VALID;
  logic [NUM_REQ-1:0]    REQ_READY;
  logic [NUM_REQ-1:0]    REQ_WRITE;
  logic [32*NUM_REQ-1:0] REQ_ADDR;
  logic [3*NUM_REQ-1:0]  REQ_SIZE;
  logic [32*NUM_REQ-1:0] REQ_WDATA;
  logic [NUM_REQ-1:0]    RSP_VALID;
  logic [31:0]           RSP_RDATA;
  logic                  RSP_ERR;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [31:0]           HWDATA;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic                  HMASTLOCK;
  logic [31:0]           HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_SIZE, REQ_WDATA,
    input  HRDATA, HREADY, HRESP,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HBURST, HPROT, HMASTLOCK
  );

  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_SIZE, REQ_WDATA,
    output HRDATA, HREADY, HRESP,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HBURST, HPROT, HMASTLOCK
  );
endinterface

// File: rtl/ahbl_master_arbiter.sv
// ---------------------------------------------------------------------------
// ahbl_master_arbiter
// Round-robin arbiter that serialises single-beat read/write commands from
// NUM_REQ requesters onto one AHB-Lite master port as non-overlapping NONSEQ
// transfers, returning read data and error status to the issuing requester.
// Ports:
//   HCLK    : bus clock, rising edge
//   HRESETN : asynchronous active-low reset
//   bus     : ahbl_master_arbiter_if.master (requester handshake + AHB-Lite)
// Misaligned or oversized commands never reach the bus; they are answered
// with an error one cycle after acceptance.
// ---------------------------------------------------------------------------
module ahbl_master_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                         HCLK,
  input  logic                         HRESETN,
  ahbl_master_arbiter_if.master        bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Only byte, halfword and word are supported, and they must be naturally aligned.
  function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = (addr_lsb[0] == 1'b0);
      3'd2:    ok = (addr_lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  state_t               state_r;
  logic [IDX_W-1:0]     ptr_r;
  logic [31:0]          cmd_wdata_r;
  logic [1:0]           htrans_r;
  logic [31:0]          haddr_r;
  logic                 hwrite_r;
  logic [2:0]           hsize_r;
  logic [31:0]          hwdata_r;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  logic [31:0]          rsp_rdata_r;
  logic                 rsp_err_r;

  logic [31:0]          req_addr_s  [NUM_REQ];
  logic [31:0]          req_wdata_s [NUM_REQ];
  logic [2:0]           req_size_s  [NUM_REQ];
  logic                 gnt_found_s;
  logic [IDX_W-1:0]     gnt_idx_s;
  logic [IDX_W-1:0]     cand_s;
  logic [NUM_REQ-1:0]   ready_s;

  // Unpack the flat per-requester command buses into arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr_s[i]  = bus.REQ_ADDR[32*i +: 32];
      req_wdata_s[i] = bus.REQ_WDATA[32*i +: 32];
      req_size_s[i]  = bus.REQ_SIZE[3*i +: 3];
    end
  end

  // Round-robin pick: walk from the farthest candidate back to ptr+1 so the
  // nearest valid requester after ptr is the last (winning) assignment.
  always_comb begin
    gnt_found_s = |bus.REQ_VALID;
    gnt_idx_s   = '0;
    cand_s      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s    = IDX_W'((int'(ptr_r) + k) % NUM_REQ);
      gnt_idx_s = bus.REQ_VALID[cand_s] ? cand_s : gnt_idx_s;
    end
  end

  // Accept is only offered in IDLE and never while reset is held.
  always_comb begin
    ready_s = '0;
    if ((state_r == ST_IDLE) && gnt_found_s && HRESETN) begin
      ready_s = onehot(gnt_idx_s);
    end else begin
      ready_s = '0;
    end
  end

  // Sequencer: accept/check in IDLE, NONSEQ in ADDR, collect result in DATA.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_r     <= ST_IDLE;
      ptr_r       <= IDX_W'(NUM_REQ - 1);
      cmd_wdata_r <= 32'h0000_0000;
      htrans_r    <= 2'b00;
      haddr_r     <= 32'h0000_0000;
      hwrite_r    <= 1'b0;
      hsize_r     <= 3'b000;
      hwdata_r    <= 32'h0000_0000;
      rsp_valid_r <= '0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (gnt_found_s) begin
            ptr_r       <= gnt_idx_s;
            cmd_wdata_r <= req_wdata_s[gnt_idx_s];
            if (cmd_legal(req_size_s[gnt_idx_s], req_addr_s[gnt_idx_s][1:0])) begin
              state_r  <= ST_ADDR;
              htrans_r <= 2'b10;
              haddr_r  <= req_addr_s[gnt_idx_s];
              hwrite_r <= bus.REQ_WRITE[gnt_idx_s];
              hsize_r  <= req_size_s[gnt_idx_s];
            end else begin
              // Rejected locally: answer next cycle, bus outputs untouched.
              rsp_valid_r <= onehot(gnt_idx_s);
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= 32'h0000_0000;
            end
          end
        end
        ST_ADDR: begin
          if (bus.HREADY) begin
            state_r  <= ST_DATA;
            htrans_r <= 2'b00;
            if (hwrite_r) begin
              hwdata_r <= cmd_wdata_r;
            end
          end
        end
        ST_DATA: begin
          // An ERROR's first (HREADY=0) cycle is just a wait; sample on HREADY=1.
          if (bus.HREADY) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= onehot(ptr_r);
            rsp_err_r   <= bus.HRESP;
            rsp_rdata_r <= hwrite_r ? 32'h0000_0000 : bus.HRDATA;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          htrans_r <= 2'b00;
        end
      endcase
    end
  end

  assign bus.REQ_READY = ready_s;
  assign bus.RSP_VALID = rsp_valid_r;
  assign bus.RSP_RDATA = rsp_rdata_r;
  assign bus.RSP_ERR   = rsp_err_r;
  assign bus.HADDR     = haddr_r;
  assign bus.HTRANS    = htrans_r;
  assign bus.HWRITE    = hwrite_r;
  assign bus.HSIZE     = hsize_r;
  assign bus.HWDATA    = hwdata_r;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = 4'b0011;
  assign bus.HMASTLOCK = 1'b0;

endmodule
